// File: rtl/apuf_crp_ctrl_pkg.sv
// Shared definitions for the arbiter-PUF challenge/response controller:
// FSM state encoding, default geometry and the majority decision.
package apuf_pkg;

    localparam int NSTAGE_DEF = 16;
    localparam int SETTLE_DEF = 8;
    localparam int NEVAL_DEF  = 5;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        FIRE,
        WAIT,
        SAMPLE,
        DISCHG,
        DONE
    } state_t;

    // True when strictly more than half of the evaluations returned 1.
    function automatic logic majority(input int ones, input int neval);
        return ones > (neval / 2);
    endfunction

endpackage

// File: rtl/apuf_crp_ctrl_if.sv
// Challenge/response handshake plus the drive/sense lines of the PUF chain.
// The controller uses the slave view; the challenge source uses master.
interface apuf_crp_ctrl_if
    import apuf_pkg::*;
#(
    parameter int nStage = NSTAGE_DEF,
    parameter int NEVAL  = NEVAL_DEF
);
    localparam int CW = $clog2(NEVAL + 1);

    logic              chal_valid;
    logic              chal_ready;
    logic [nStage-1:0] chal;
    logic [nStage-1:0] cT;
    logic [nStage-1:0] cB;
    logic              trig;
    logic              arb_out;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp;
    logic [CW-1:0]     resp_ones;

    modport master (
        output chal_valid, chal, arb_out, resp_ready,
        input  chal_ready, cT, cB, trig, resp_valid, resp, resp_ones
    );

    modport slave (
        input  chal_valid, chal, arb_out, resp_ready,
        output chal_ready, cT, cB, trig, resp_valid, resp, resp_ones
    );

endinterface

// File: rtl/apuf_crp_ctrl_sync2.sv
// Two-flop synchroniser with asynchronous active-high reset, used to bring
// the free-running arbiter decision into the clk domain.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/apuf_crp_ctrl.sv
// Arbiter-PUF challenge/response controller: latches a challenge, fires the
// race NEVAL times with discharge gaps, and returns the majority-voted bit.
module apuf_crp_ctrl
    import apuf_pkg::*;
#(
    parameter int nStage = NSTAGE_DEF,
    parameter int SETTLE = SETTLE_DEF,
    parameter int NEVAL  = NEVAL_DEF
) (
    input logic              clk,
    input logic              rst,
    apuf_crp_ctrl_if.slave   bus
);
    localparam int CW = $clog2(NEVAL + 1);
    localparam int WW = $clog2(SETTLE);

    state_t        state;
    logic [CW-1:0] eval_cnt;
    logic [CW-1:0] ones;
    logic [WW-1:0] wait_cnt;
    logic          arb_s;
    logic [CW-1:0] ones_nxt;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.arb_out),
        .q   (arb_s)
    );

    assign ones_nxt = ones + CW'(arb_s);

    // Outputs are set on the transition into a state so they are glitch-free
    // and valid for the whole state duration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            eval_cnt       <= '0;
            ones           <= '0;
            wait_cnt       <= '0;
            bus.chal_ready <= 1'b0;
            bus.cT         <= '0;
            bus.cB         <= '0;
            bus.trig       <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp       <= 1'b0;
            bus.resp_ones  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.chal_ready <= 1'b1;
                    if (bus.chal_valid && bus.chal_ready) begin
                        bus.cT         <= bus.chal;
                        bus.cB         <= bus.chal;
                        eval_cnt       <= '0;
                        ones           <= '0;
                        bus.chal_ready <= 1'b0;
                        state          <= ARM;
                    end
                end
                ARM: begin
                    bus.trig <= 1'b1;
                    state    <= FIRE;
                end
                FIRE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == WW'(SETTLE - 1)) begin
                        bus.trig <= 1'b0;
                        state    <= SAMPLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    ones     <= ones_nxt;
                    eval_cnt <= eval_cnt + 1'b1;
                    if (eval_cnt == CW'(NEVAL - 1)) begin
                        bus.resp_valid <= 1'b1;
                        bus.resp       <= majority(int'(ones_nxt), NEVAL);
                        bus.resp_ones  <= ones_nxt;
                        state          <= DONE;
                    end else begin
                        wait_cnt <= '0;
                        state    <= DISCHG;
                    end
                end
                DISCHG: begin
                    if (wait_cnt == WW'(SETTLE - 1)) begin
                        bus.trig <= 1'b1;
                        state    <= FIRE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        bus.chal_ready <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apuf_crp_ctrl.sv
// Directed bench for apuf_crp_ctrl: reset, constant and mixed arbiter
// decisions, backpressure, mid-evaluation reset and back-to-back challenges.
module tb_apuf_crp_ctrl;
    import apuf_pkg::*;

    localparam int NS = 16;
    localparam int ST = 8;
    localparam int NE = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apuf_crp_ctrl_if #(.nStage(NS), .NEVAL(NE)) bus ();

    apuf_crp_ctrl #(.nStage(NS), .SETTLE(ST), .NEVAL(NE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic       r;
        logic [2:0] ones;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [4:0] bits);
        exp_t e;
        e.ones = 3'($countones(bits));
        e.r    = ($countones(bits) > 2);
        sb.push_back(e);
    endtask

    task automatic pop_chk();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk("resp", 32'(bus.resp), 32'(e.r));
            chk("resp_ones", 32'(bus.resp_ones), 32'(e.ones));
        end
    endtask

    // Runs one challenge from a negedge; bits[i] is the arbiter decision for
    // evaluation i. abort_ev > 0 pulses rst in WAIT of that evaluation.
    task automatic do_chal(input logic [15:0] c, input logic [4:0] bits,
                           input int hold, input int abort_ev);
        int   cyc;
        int   pulse;
        int   hi;
        logic pt;
        cyc = 0;
        while (!bus.chal_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("ready_before_accept", 32'(bus.chal_ready), 32'd1);
        bus.chal       = c;
        bus.chal_valid = 1'b1;
        @(posedge clk);
        push_exp(bits);
        @(negedge clk);
        bus.chal_valid = 1'b0;
        bus.chal       = ~c;
        cyc   = 0;
        pulse = 0;
        hi    = 0;
        pt    = 1'b0;
        while (!bus.resp_valid && cyc < 200) begin
            if (bus.trig && !pt) begin
                if (pulse < 5) bus.arb_out = bits[pulse];
                chk("cT_held", 32'(bus.cT), 32'(c));
                chk("cB_held", 32'(bus.cB), 32'(c));
                pulse++;
                hi = 0;
            end
            if (bus.trig) hi++;
            if (!bus.trig && pt) chk("trig_high_len", 32'(hi), 32'd9);
            if (abort_ev == pulse && bus.trig && hi == 4) begin
                rst = 1'b1;
                #1;
                chk("abort_trig", 32'(bus.trig), 32'd0);
                chk("abort_ready", 32'(bus.chal_ready), 32'd0);
                chk("abort_cT", 32'(bus.cT), 32'd0);
                void'(sb.pop_back());
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                chk("abort_idle_ready", 32'(bus.chal_ready), 32'd1);
                return;
            end
            pt = bus.trig;
            @(negedge clk);
            cyc++;
        end
        chk("latency", 32'(cyc), 32'd83);
        chk("pulse_count", 32'(pulse), 32'd5);
        bus.resp_ready = 1'b0;
        bus.chal_valid = 1'b1;
        bus.chal       = 16'h1234;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.resp_valid), 32'd1);
            chk("bp_ready_low", 32'(bus.chal_ready), 32'd0);
            chk("bp_cT", 32'(bus.cT), 32'(c));
            if (sb.size() > 0) begin
                chk("bp_resp", 32'(bus.resp), 32'(sb[0].r));
                chk("bp_ones", 32'(bus.resp_ones), 32'(sb[0].ones));
            end
        end
        bus.chal_valid = 1'b0;
        bus.resp_ready = 1'b1;
        pop_chk();
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("post_hs_valid", 32'(bus.resp_valid), 32'd0);
        chk("post_hs_ready", 32'(bus.chal_ready), 32'd1);
    endtask

    initial begin
        int acc[$];
        int cyc;
        bus.chal_valid = 1'b0;
        bus.chal       = '0;
        bus.arb_out    = 1'b0;
        bus.resp_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_trig", 32'(bus.trig), 32'd0);
        chk("rst_chal_ready", 32'(bus.chal_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp", 32'(bus.resp), 32'd0);
        chk("rst_resp_ones", 32'(bus.resp_ones), 32'd0);
        chk("rst_cT", 32'(bus.cT), 32'd0);
        chk("rst_cB", 32'(bus.cB), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_ready_before_edge", 32'(bus.chal_ready), 32'd0);
        @(negedge clk);
        chk("rel_ready_after_edge", 32'(bus.chal_ready), 32'd1);

        bus.arb_out = 1'b1;
        do_chal(16'hA5A5, 5'b11111, 10, 0);
        do_chal(16'h3C3C, 5'b00101, 2, 0);
        do_chal(16'hC3C3, 5'b10011, 0, 0);
        do_chal(16'h5555, 5'b11111, 0, 3);
        chk("abort_discarded", 32'(sb.size()), 32'd0);
        do_chal(16'hAAAA, 5'b11111, 0, 0);

        bus.arb_out    = 1'b1;
        bus.chal       = 16'h0F0F;
        bus.chal_valid = 1'b1;
        bus.resp_ready = 1'b1;
        cyc = 0;
        while (acc.size() < 3 && cyc < 400) begin
            if (bus.chal_ready && bus.chal_valid) begin
                acc.push_back(cyc);
                push_exp(5'b11111);
            end
            if (bus.resp_valid && bus.resp_ready) pop_chk();
            @(negedge clk);
            cyc++;
        end
        bus.chal_valid = 1'b0;
        chk("b2b_accepts", 32'(acc.size()), 32'd3);
        if (acc.size() == 3) begin
            chk("b2b_period_1", 32'(acc[1] - acc[0]), 32'd85);
            chk("b2b_period_2", 32'(acc[2] - acc[1]), 32'd85);
        end
        cyc = 0;
        while (!bus.resp_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b_last_valid", 32'(bus.resp_valid), 32'd1);
        pop_chk();
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("b2b_drained", 32'(sb.size()), 32'd0);
        chk("b2b_idle_ready", 32'(bus.chal_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
